mem_arbiter: RTL and testbench

- Responder end of the cache-to-memory interface. Serves instruction-cache fills (iREN/iaddr) and data-cache reads and writes (dREN/dWEN/daddr) over one shared single-port RAM.
- Registered FSM holds one grant until the RAM signals ACCESS; waits are returned combinationally.
- Sits between the cache pair and the RAM model, under the top-level memory system.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory path: data word, RAM status codes and
// the state encoding of the memory arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM model on every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter grant state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-port RAM between instruction fills and
// data reads/writes. Data has strict priority. Defining MEMARB_STARVE_GUARD_EN
// adds a streak counter that forces an instruction grant after MAX_DSTREAK
// back-to-back data completions while an instruction fill is waiting.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  if (MAX_DSTREAK == 0) begin : g_bad_max_dstreak
    $error("MAX_DSTREAK must be at least 1");
  end

  arb_state_t r_state_q, r_state_d;
  ramstate_t  w_ramstate;
  logic       w_dreq;
  logic       w_guard;

  assign w_ramstate = ramstate_t'(ramstate);
  assign w_dreq     = dREN | dWEN;

  // Read data is a straight pass-through; the wait signals qualify it.
  assign iload = ramload;
  assign dload = ramload;

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state_q <= IDLE;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  // Next-state and output decode; strobes are gated by the live request so a
  // dropped request aborts without a completion pulse.
  always_comb begin
    r_state_d = r_state_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (r_state_q)
      IDLE: begin
        if (w_guard) begin
          r_state_d = IGRANT;
        end else if (w_dreq) begin
          r_state_d = DGRANT;
        end else if (iREN) begin
          r_state_d = IGRANT;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          r_state_d = IDLE;
        end else if (w_ramstate == ACCESS) begin
          iwait     = 1'b0;
          r_state_d = IDLE;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!w_dreq) begin
          r_state_d = IDLE;
        end else if (w_ramstate == ACCESS) begin
          dwait     = 1'b0;
          r_state_d = IDLE;
        end
      end
      default: r_state_d = IDLE;
    endcase
  end

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int unsigned StreakW = $clog2(MAX_DSTREAK + 1);

  logic [StreakW-1:0] r_streak_q, r_streak_d;
  logic               w_dcomplete;

  assign w_dcomplete = (r_state_q == DGRANT) && !dwait;
  assign w_guard     = iREN && (r_streak_q == StreakW'(MAX_DSTREAK));

  // Count data completions that overtook a waiting instruction fill.
  always_comb begin
    r_streak_d = r_streak_q;
    if (!iREN || ((r_state_q == IDLE) && (r_state_d == IGRANT))) begin
      r_streak_d = '0;
    end else if (w_dcomplete && (r_streak_q != StreakW'(MAX_DSTREAK))) begin
      r_streak_d = r_streak_q + 1'b1;
    end
  end

  // Streak counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_streak_q <= '0;
    end else begin
      r_streak_q <= r_streak_d;
    end
  end
`else
  assign w_guard = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table, a read-data
// scoreboard, plus hand-written reset and starvation sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        iren, dren, dwen;
    logic [1:0]  rs;
    logic [31:0] iaddr, daddr, dstore, rload;
    logic        eiw, edw, eren, ewen;
    logic        chka;
    logic [31:0] eaddr;
    logic        chks;
    logic [31:0] estore;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          sb_en = 1'b0;
  int          ev[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iren, input logic dren, input logic dwen, input logic [1:0] rs,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                     input logic [31:0] rl, input logic eiw, input logic edw, input logic eren,
                     input logic ewen, input logic chka, input logic [31:0] eaddr,
                     input logic chks, input logic [31:0] estore);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
    v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rload = rl;
    v.eiw = eiw; v.edw = edw; v.eren = eren; v.ewen = ewen;
    v.chka = chka; v.eaddr = eaddr; v.chks = chks; v.estore = estore;
    vecs.push_back(v);
  endtask

  // Scoreboard: every completion pulse must match the oldest expected load.
  always @(negedge CLK) begin
    if (sb_en && nRST === 1'b1) begin
      if (iwait === 1'b0) begin
        if (iq.size() == 0) chk("iwait_unexpected", {31'b0, iwait}, 32'd1);
        else chk("iload", iload, iq.pop_front());
      end
      if (dwait === 1'b0) begin
        if (dq.size() == 0) chk("dwait_unexpected", {31'b0, dwait}, 32'd1);
        else chk("dload", dload, dq.pop_front());
      end
    end
  end

  initial begin
    int bcnt;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Vector table: one entry per cycle, starting from IDLE.
    // Instruction fill with three BUSY cycles before ACCESS.
    add(1, 0, 0, FREE,   32'h40, 0, 0, 32'h2001_0005, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, BUSY,   32'h40, 0, 0, 32'h2001_0005, 1, 1, 1, 0, 1, 32'h40, 0, 0);
    add(1, 0, 0, BUSY,   32'h40, 0, 0, 32'h2001_0005, 1, 1, 1, 0, 1, 32'h40, 0, 0);
    add(1, 0, 0, BUSY,   32'h40, 0, 0, 32'h2001_0005, 1, 1, 1, 0, 1, 32'h40, 0, 0);
    add(1, 0, 0, ACCESS, 32'h40, 0, 0, 32'h2001_0005, 0, 1, 1, 0, 1, 32'h40, 0, 0);
    add(0, 0, 0, FREE,   32'h40, 0, 0, 32'h2001_0005, 1, 1, 0, 0, 1, 0, 0, 0);
    // Simultaneous iREN and write (with dREN too): write wins, then fill.
    add(1, 1, 1, FREE,   32'h80, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, BUSY,   32'h80, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 1, 1, 0, 1,
        1, 32'h100, 1, 32'hDEAD_BEEF);
    add(1, 1, 1, ACCESS, 32'h80, 32'h100, 32'hDEAD_BEEF, 32'h1111_1111, 1, 0, 0, 1,
        1, 32'h100, 1, 32'hDEAD_BEEF);
    add(1, 0, 0, FREE,   32'h80, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, BUSY,   32'h80, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 1, 0, 1, 32'h80, 0, 0);
    add(1, 0, 0, ACCESS, 32'h80, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 1, 0, 1, 32'h80, 0, 0);
    add(0, 0, 0, FREE,   32'h80, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 0, 0, 1, 0, 0, 0);
    // Data read retried through two ERROR cycles.
    add(0, 1, 0, FREE,   0, 32'h200, 32'h77, 32'hCAFE_F00D, 1, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, ERROR,  0, 32'h200, 32'h77, 32'hCAFE_F00D, 1, 1, 1, 0, 1, 32'h200, 1, 32'h77);
    add(0, 1, 0, ERROR,  0, 32'h200, 32'h77, 32'hCAFE_F00D, 1, 1, 1, 0, 1, 32'h200, 1, 32'h77);
    add(0, 1, 0, ACCESS, 0, 32'h200, 32'h77, 32'hCAFE_F00D, 1, 0, 1, 0, 1, 32'h200, 1, 32'h77);
    add(0, 0, 0, FREE,   0, 32'h200, 32'h77, 32'hCAFE_F00D, 1, 1, 0, 0, 1, 0, 0, 0);
    // Data read aborted while BUSY; waiting fill granted afterwards.
    add(1, 1, 0, FREE,   32'h44, 32'h300, 0, 32'hABCD_0001, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, BUSY,   32'h44, 32'h300, 0, 32'hABCD_0001, 1, 1, 1, 0, 1, 32'h300, 0, 0);
    add(1, 0, 0, BUSY,   32'h44, 32'h300, 0, 32'hABCD_0001, 1, 1, 0, 0, 1, 32'h300, 0, 0);
    add(1, 0, 0, FREE,   32'h44, 32'h300, 0, 32'hABCD_0001, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, BUSY,   32'h44, 32'h300, 0, 32'hABCD_0001, 1, 1, 1, 0, 1, 32'h44, 0, 0);
    add(1, 0, 0, ACCESS, 32'h44, 32'h300, 0, 32'hABCD_0001, 0, 1, 1, 0, 1, 32'h44, 0, 0);
    add(0, 0, 0, FREE,   32'h44, 32'h300, 0, 32'hABCD_0001, 1, 1, 0, 0, 1, 0, 0, 0);

    // Reset state.
    @(negedge CLK);
    chk("rst_iwait", {31'b0, iwait}, 32'd1);
    chk("rst_dwait", {31'b0, dwait}, 32'd1);
    chk("rst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    sb_en = 1'b1;

    foreach (vecs[k]) begin
      iREN = vecs[k].iren; dREN = vecs[k].dren; dWEN = vecs[k].dwen;
      ramstate = vecs[k].rs; iaddr = vecs[k].iaddr; daddr = vecs[k].daddr;
      dstore = vecs[k].dstore; ramload = vecs[k].rload;
      if (!vecs[k].eiw) iq.push_back(vecs[k].rload);
      if (!vecs[k].edw) dq.push_back(vecs[k].rload);
      @(negedge CLK);
      chk($sformatf("v%0d_iwait", k), {31'b0, iwait}, {31'b0, vecs[k].eiw});
      chk($sformatf("v%0d_dwait", k), {31'b0, dwait}, {31'b0, vecs[k].edw});
      chk($sformatf("v%0d_ramREN", k), {31'b0, ramREN}, {31'b0, vecs[k].eren});
      chk($sformatf("v%0d_ramWEN", k), {31'b0, ramWEN}, {31'b0, vecs[k].ewen});
      if (vecs[k].chka) chk($sformatf("v%0d_ramaddr", k), ramaddr, vecs[k].eaddr);
      if (vecs[k].chks) chk($sformatf("v%0d_ramstore", k), ramstore, vecs[k].estore);
      @(posedge CLK); #1;
    end
    chk("iq_drained", iq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);

    // Asynchronous reset in the middle of a granted write.
    iREN = 0; dREN = 0; dWEN = 1; daddr = 32'h500; dstore = 32'h55AA; ramstate = BUSY;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("t1_pre_ramWEN", {31'b0, ramWEN}, 32'd1);
    chk("t1_pre_ramaddr", ramaddr, 32'h500);
    #2 nRST = 1'b0;
    #1;
    chk("t1_rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    chk("t1_rst_ramREN", {31'b0, ramREN}, 32'd0);
    chk("t1_rst_dwait", {31'b0, dwait}, 32'd1);
    chk("t1_rst_iwait", {31'b0, iwait}, 32'd1);
    chk("t1_rst_ramaddr", ramaddr, 32'd0);
    chk("t1_rst_ramstore", ramstore, 32'd0);
    dWEN = 0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk($sformatf("t1_post%0d_strobes", c), {30'b0, ramREN, ramWEN}, 32'd0);
      chk($sformatf("t1_post%0d_ramaddr", c), ramaddr, 32'd0);
      @(posedge CLK); #1;
    end

    // Both sides requesting continuously; RAM answers on the second granted cycle.
    sb_en = 1'b0;
    iREN = 1; dREN = 1; dWEN = 0; ramstate = FREE; bcnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (ramREN || ramWEN) begin
        bcnt++;
        ramstate = (bcnt >= 2) ? ACCESS : BUSY;
      end else begin
        bcnt = 0;
        ramstate = FREE;
      end
      @(negedge CLK);
      if (!dwait && !iwait) chk("t6_both_waits_low", {30'b0, iwait, dwait}, 32'd3);
      if (!dwait) ev.push_back(0);
      if (!iwait) ev.push_back(1);
      @(posedge CLK); #1;
    end
    iREN = 0; dREN = 0;
    chk("t6_pulse_count_ge10", {31'b0, ev.size() >= 10}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      int exp_ev;
`ifdef MEMARB_STARVE_GUARD_EN
      exp_ev = (k % 5 == 4) ? 1 : 0;
`else
      exp_ev = 0;
`endif
      if (k < ev.size()) chk($sformatf("t6_pulse%0d_is_i", k), ev[k], exp_ev);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
